// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: latches the PC, runs a req/ready memory read and
// hands the word to decode over valid/ready. Optional REQ timeout: FETCH_TIMEOUT_EN.
module fetch_ctrl #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter logic [DATA_W-1:0] NOP_WORD = '0,
    parameter int unsigned       TIMEOUT  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              pc_en,
    input  logic              flush,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              fetch_misalign,
    output logic              fetch_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_VALID = 2'd2
    } state_t;

    state_t            state, state_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] instr_d;
    logic [ADDR_W-1:0] instr_pc_d;
    logic              instr_valid_d;
    logic              fetch_misalign_d;

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt, cnt_d;
    logic             fetch_err_q, fetch_err_d;
`endif

    // Handshake outputs are decoded from state so they change exactly at the edge.
    assign mem_req = (state == S_REQ);
    assign pc_en   = ((state == S_VALID) && instr_ready) || flush;

    always_comb begin
        state_d          = state;
        mem_addr_d       = mem_addr;
        instr_d          = instr;
        instr_pc_d       = instr_pc;
        instr_valid_d    = instr_valid;
        fetch_misalign_d = fetch_misalign;
`ifdef FETCH_TIMEOUT_EN
        cnt_d            = cnt;
        fetch_err_d      = fetch_err_q;
`endif

        if (flush) begin
            // Redirect beats everything, including a coincident mem_ready.
            state_d          = S_IDLE;
            instr_valid_d    = 1'b0;
            fetch_misalign_d = 1'b0;
`ifdef FETCH_TIMEOUT_EN
            fetch_err_d      = 1'b0;
`endif
        end else begin
            unique case (state)
                S_IDLE: begin
                    mem_addr_d = pc_in;
                    instr_pc_d = pc_in;
                    if (pc_in[1:0] == 2'b00) begin
                        state_d = S_REQ;
`ifdef FETCH_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end else begin
                        state_d          = S_VALID;
                        instr_d          = NOP_WORD;
                        instr_valid_d    = 1'b1;
                        fetch_misalign_d = 1'b1;
                    end
                end
                S_REQ: begin
                    if (mem_ready) begin
                        state_d       = S_VALID;
                        instr_d       = mem_rdata;
                        instr_valid_d = 1'b1;
                    end
`ifdef FETCH_TIMEOUT_EN
                    else if (cnt == CNT_LAST) begin
                        state_d       = S_VALID;
                        instr_d       = NOP_WORD;
                        instr_valid_d = 1'b1;
                        fetch_err_d   = 1'b1;
                    end else begin
                        cnt_d = cnt + 1'b1;
                    end
`endif
                end
                S_VALID: begin
                    if (instr_ready) begin
                        state_d          = S_IDLE;
                        instr_valid_d    = 1'b0;
                        fetch_misalign_d = 1'b0;
`ifdef FETCH_TIMEOUT_EN
                        fetch_err_d      = 1'b0;
`endif
                    end
                end
                default: begin
                    state_d       = S_IDLE;
                    instr_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            mem_addr       <= '0;
            instr          <= NOP_WORD;
            instr_pc       <= '0;
            instr_valid    <= 1'b0;
            fetch_misalign <= 1'b0;
        end else begin
            state          <= state_d;
            mem_addr       <= mem_addr_d;
            instr          <= instr_d;
            instr_pc       <= instr_pc_d;
            instr_valid    <= instr_valid_d;
            fetch_misalign <= fetch_misalign_d;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            fetch_err_q <= 1'b0;
        end else begin
            cnt         <= cnt_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    assign fetch_err = fetch_err_q;
`else
    assign fetch_err = 1'b0;
`endif

endmodule
